trb_mem_scheduler: RTL and testbench

//  Shares one single-port trace memory (2**ADDR_WIDTH x WIDTH) between three requesters:

---
 rtl/trb_mem_scheduler.sv | 130 +++++++++++++
 tb/tb_trb_mem_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/trb_mem_scheduler.sv
// Single-port trace RAM scheduler: LW > round-robin(LR,SY) with starvation bound and read-tag return.
// Optional stall counters built when TRB_SCHED_STALL_STATS_EN is defined.
module trb_mem_scheduler #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  LW_REQ_I,
  input  logic [ADDR_WIDTH-1:0] LW_ADDR_I,
  input  logic [WIDTH-1:0]      LW_DATA_I,
  output logic                  LW_GNT_O,
  input  logic                  LR_REQ_I,
  input  logic [ADDR_WIDTH-1:0] LR_ADDR_I,
  output logic                  LR_GNT_O,
  output logic                  LR_RVALID_O,
  output logic [WIDTH-1:0]      LR_RDATA_O,
  input  logic                  SY_REQ_I,
  input  logic                  SY_WE_I,
  input  logic [ADDR_WIDTH-1:0] SY_ADDR_I,
  input  logic [WIDTH-1:0]      SY_WDATA_I,
  output logic                  SY_GNT_O,
  output logic                  SY_RVALID_O,
  output logic [WIDTH-1:0]      SY_RDATA_O,
  output logic                  MEM_EN_O,
  output logic                  MEM_WE_O,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR_O,
  output logic [WIDTH-1:0]      MEM_WDATA_O,
  input  logic [WIDTH-1:0]      MEM_RDATA_I,
  output logic [47:0]           STALL_CNT_O
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic {RR_LR, RR_SY} rr_t;

  rr_t                  rr_q;
  logic [WCW-1:0]       wait_q;
  logic [MEM_LATENCY-1:0] lr_tag_q, sy_tag_q;

  logic rr_req, pick_lr, force_rr, rr_win;
  logic lw_gnt, lr_gnt, sy_gnt;

  always_comb begin
    rr_req   = LR_REQ_I | SY_REQ_I;
    pick_lr  = LR_REQ_I & (~SY_REQ_I | (rr_q == RR_LR));
    force_rr = (wait_q == WCW'(MAX_WAIT));
    // A saturated wait counter hands the cycle to the RR winner even over LW.
    lw_gnt   = ~RST_I & LW_REQ_I & ~(force_rr & rr_req);
    rr_win   = ~RST_I & rr_req & (~LW_REQ_I | force_rr);
    lr_gnt   = rr_win & pick_lr;
    sy_gnt   = rr_win & ~pick_lr;
  end

  always_comb begin
    LW_GNT_O    = lw_gnt;
    LR_GNT_O    = lr_gnt;
    SY_GNT_O    = sy_gnt;
    MEM_EN_O    = lw_gnt | lr_gnt | sy_gnt;
    MEM_WE_O    = lw_gnt | (sy_gnt & SY_WE_I);
    MEM_ADDR_O  = '0;
    MEM_WDATA_O = '0;
    if (lw_gnt) begin
      MEM_ADDR_O  = LW_ADDR_I;
      MEM_WDATA_O = LW_DATA_I;
    end else if (lr_gnt) begin
      MEM_ADDR_O  = LR_ADDR_I;
    end else if (sy_gnt) begin
      MEM_ADDR_O  = SY_ADDR_I;
      if (SY_WE_I) MEM_WDATA_O = SY_WDATA_I;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rr_q   <= RR_LR;
      wait_q <= '0;
    end else begin
      if (lr_gnt)      rr_q <= RR_SY;
      else if (sy_gnt) rr_q <= RR_LR;
      if (lr_gnt | sy_gnt | ~rr_req) wait_q <= '0;
      else if (lw_gnt && wait_q != WCW'(MAX_WAIT)) wait_q <= wait_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      lr_tag_q    <= '0;
      sy_tag_q    <= '0;
      LR_RVALID_O <= 1'b0;
      SY_RVALID_O <= 1'b0;
      LR_RDATA_O  <= '0;
      SY_RDATA_O  <= '0;
    end else begin
      lr_tag_q[0] <= lr_gnt;
      sy_tag_q[0] <= sy_gnt & ~SY_WE_I;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        lr_tag_q[i] <= lr_tag_q[i-1];
        sy_tag_q[i] <= sy_tag_q[i-1];
      end
      LR_RVALID_O <= lr_tag_q[MEM_LATENCY-1];
      SY_RVALID_O <= sy_tag_q[MEM_LATENCY-1];
      if (lr_tag_q[MEM_LATENCY-1]) LR_RDATA_O <= MEM_RDATA_I;
      if (sy_tag_q[MEM_LATENCY-1]) SY_RDATA_O <= MEM_RDATA_I;
    end
  end

`ifdef TRB_SCHED_STALL_STATS_EN
  logic [15:0] lw_cnt_q, lr_cnt_q, sy_cnt_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      lw_cnt_q <= '0;
      lr_cnt_q <= '0;
      sy_cnt_q <= '0;
    end else begin
      if (LW_REQ_I & ~lw_gnt & (lw_cnt_q != '1)) lw_cnt_q <= lw_cnt_q + 1'b1;
      if (LR_REQ_I & ~lr_gnt & (lr_cnt_q != '1)) lr_cnt_q <= lr_cnt_q + 1'b1;
      if (SY_REQ_I & ~sy_gnt & (sy_cnt_q != '1)) sy_cnt_q <= sy_cnt_q + 1'b1;
    end
  end

  assign STALL_CNT_O = {lw_cnt_q, lr_cnt_q, sy_cnt_q};
`else
  assign STALL_CNT_O = '0;
`endif

endmodule

// File: tb/tb_trb_mem_scheduler.sv
// Directed bench for trb_mem_scheduler with a latency-1 behavioural RAM.
module tb_trb_mem_scheduler;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        LW_REQ_I = 1'b0, LR_REQ_I = 1'b0, SY_REQ_I = 1'b0, SY_WE_I = 1'b0;
  logic [7:0]  LW_ADDR_I = '0, LR_ADDR_I = '0, SY_ADDR_I = '0;
  logic [31:0] LW_DATA_I = '0, SY_WDATA_I = '0;
  logic        LW_GNT_O, LR_GNT_O, SY_GNT_O, LR_RVALID_O, SY_RVALID_O;
  logic [31:0] LR_RDATA_O, SY_RDATA_O, MEM_WDATA_O;
  logic        MEM_EN_O, MEM_WE_O;
  logic [7:0]  MEM_ADDR_O;
  logic [31:0] MEM_RDATA_I = '0;
  logic [47:0] STALL_CNT_O;

  logic [31:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  trb_mem_scheduler #(.WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(1), .MAX_WAIT(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .LW_REQ_I(LW_REQ_I), .LW_ADDR_I(LW_ADDR_I), .LW_DATA_I(LW_DATA_I), .LW_GNT_O(LW_GNT_O),
    .LR_REQ_I(LR_REQ_I), .LR_ADDR_I(LR_ADDR_I), .LR_GNT_O(LR_GNT_O),
    .LR_RVALID_O(LR_RVALID_O), .LR_RDATA_O(LR_RDATA_O),
    .SY_REQ_I(SY_REQ_I), .SY_WE_I(SY_WE_I), .SY_ADDR_I(SY_ADDR_I), .SY_WDATA_I(SY_WDATA_I),
    .SY_GNT_O(SY_GNT_O), .SY_RVALID_O(SY_RVALID_O), .SY_RDATA_O(SY_RDATA_O),
    .MEM_EN_O(MEM_EN_O), .MEM_WE_O(MEM_WE_O), .MEM_ADDR_O(MEM_ADDR_O),
    .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(MEM_RDATA_I), .STALL_CNT_O(STALL_CNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) begin
    if (MEM_EN_O) begin
      if (MEM_WE_O) mem[MEM_ADDR_O] <= MEM_WDATA_O;
      else          MEM_RDATA_I <= mem[MEM_ADDR_O];
    end
  end

  typedef struct {
    logic        lw, lr, sy, sy_we;
    logic [7:0]  lw_a, lr_a, sy_a;
    logic [31:0] lw_d, sy_d;
    logic [2:0]  exp_gnt;   // {lw, lr, sy}
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    LW_REQ_I = 0; LR_REQ_I = 0; SY_REQ_I = 0; SY_WE_I = 0;
    LW_ADDR_I = '0; LR_ADDR_I = '0; SY_ADDR_I = '0; LW_DATA_I = '0; SY_WDATA_I = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK_I); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    //        lw lr sy we  lw_a   lr_a   sy_a   lw_d          sy_d          gnt     we  addr   wdata
    vecs[0] = '{1, 0, 0, 0, 8'h05, 8'h00, 8'h00, 32'hDEADBEEF, 32'h0,        3'b100, 1, 8'h05, 32'hDEADBEEF};
    vecs[1] = '{0, 1, 0, 0, 8'h00, 8'h10, 8'h00, 32'h0,        32'h0,        3'b010, 0, 8'h10, 32'h0};
    vecs[2] = '{0, 0, 1, 1, 8'h00, 8'h00, 8'h20, 32'h0,        32'h00001234, 3'b001, 1, 8'h20, 32'h00001234};
    vecs[3] = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h21, 32'h0,        32'hAAAAAAAA, 3'b001, 0, 8'h21, 32'h0};
    vecs[4] = '{0, 1, 1, 0, 8'h00, 8'h30, 8'h31, 32'h0,        32'h0,        3'b010, 0, 8'h30, 32'h0};
    vecs[5] = '{1, 1, 1, 1, 8'h40, 8'h41, 8'h42, 32'h11111111, 32'h22222222, 3'b100, 1, 8'h40, 32'h11111111};
    vecs[6] = '{0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 32'h0,        32'h0,        3'b000, 0, 8'h00, 32'h0};
    vecs[7] = '{0, 1, 1, 1, 8'h00, 8'h50, 8'h51, 32'h0,        32'h55555555, 3'b010, 0, 8'h50, 32'h0};

    do_reset();
    #1;
    check("reset_rvalid", {62'd0, LR_RVALID_O, SY_RVALID_O}, 64'd0);
    check("reset_rdata", {LR_RDATA_O, SY_RDATA_O}, 64'd0);
    check("reset_stall", {16'd0, STALL_CNT_O}, 64'd0);
    check("reset_idle_mem", {62'd0, MEM_EN_O, MEM_WE_O}, 64'd0);

    foreach (vecs[k]) begin
      do_reset();
      LW_REQ_I = vecs[k].lw; LR_REQ_I = vecs[k].lr; SY_REQ_I = vecs[k].sy; SY_WE_I = vecs[k].sy_we;
      LW_ADDR_I = vecs[k].lw_a; LR_ADDR_I = vecs[k].lr_a; SY_ADDR_I = vecs[k].sy_a;
      LW_DATA_I = vecs[k].lw_d; SY_WDATA_I = vecs[k].sy_d;
      #1;
      check($sformatf("vec%0d_gnt", k), {61'd0, LW_GNT_O, LR_GNT_O, SY_GNT_O}, {61'd0, vecs[k].exp_gnt});
      check($sformatf("vec%0d_en_we", k), {62'd0, MEM_EN_O, MEM_WE_O},
            {62'd0, |vecs[k].exp_gnt, vecs[k].exp_we});
      check($sformatf("vec%0d_addr", k), {56'd0, MEM_ADDR_O}, {56'd0, vecs[k].exp_addr});
      check($sformatf("vec%0d_wdata", k), {32'd0, MEM_WDATA_O}, {32'd0, vecs[k].exp_wdata});
      step();
      clear_inputs();
    end

    // SY read of the LW-written word: pulse two cycles after grant, data held afterwards
    do_reset();
    SY_REQ_I = 1; SY_WE_I = 0; SY_ADDR_I = 8'h05;
    #1 check("sy_rd_gnt", {63'd0, SY_GNT_O}, 64'd1);
    step(); clear_inputs();
    #1 check("sy_rd_n1_rvalid", {63'd0, SY_RVALID_O}, 64'd0);
    step();
    check("sy_rd_n2_rvalid", {62'd0, SY_RVALID_O, LR_RVALID_O}, 64'd2);
    check("sy_rd_n2_data", {32'd0, SY_RDATA_O}, 64'hDEADBEEF);
    step();
    check("sy_rd_n3_rvalid", {63'd0, SY_RVALID_O}, 64'd0);
    check("sy_rd_n3_hold", {32'd0, SY_RDATA_O}, 64'hDEADBEEF);

    // LR and SY both pending: alternate starting with LR, results routed to owner
    do_reset();
    LR_REQ_I = 1; LR_ADDR_I = 8'h05; SY_REQ_I = 1; SY_WE_I = 0; SY_ADDR_I = 8'h20;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr_c%0d_gnt", c), {61'd0, LW_GNT_O, LR_GNT_O, SY_GNT_O},
            (c % 2 == 0) ? 64'd2 : 64'd1);
      if (c == 2) check("rr_lr_return", {31'd0, LR_RVALID_O, LR_RDATA_O}, {31'd0, 1'b1, 32'hDEADBEEF});
      if (c == 3) check("rr_sy_return", {31'd0, SY_RVALID_O, SY_RDATA_O}, {31'd0, 1'b1, 32'h00001234});
      @(posedge CLK_I); #1;
    end
    clear_inputs();

    // LW streaming with SY pending: starvation bound forces SY on the 5th cycle
    do_reset();
    LW_REQ_I = 1; LW_ADDR_I = 8'h60; LW_DATA_I = 32'h77;
    SY_REQ_I = 1; SY_WE_I = 0; SY_ADDR_I = 8'h05;
    for (int c = 1; c <= 10; c++) begin
      #1;
      check($sformatf("starve_c%0d_gnt", c), {62'd0, LW_GNT_O, SY_GNT_O},
            (c == 5) ? 64'd1 : 64'd2);
      @(posedge CLK_I); #1;
      if (c == 5) SY_REQ_I = 0;
    end
    clear_inputs();
    #1;
`ifdef TRB_SCHED_STALL_STATS_EN
    check("stall_counts", {16'd0, STALL_CNT_O}, {16'd0, 16'd1, 16'd0, 16'd4});
`else
    check("stall_counts", {16'd0, STALL_CNT_O}, 64'd0);
`endif

    // Reads in flight when reset hits are dropped
    do_reset();
    SY_REQ_I = 1; SY_WE_I = 0; SY_ADDR_I = 8'h05;
    #1 check("flush_gnt0", {63'd0, SY_GNT_O}, 64'd1);
    step();
    check("flush_gnt1", {63'd0, SY_GNT_O}, 64'd1);
    RST_I = 1'b1;
    #1 check("flush_no_gnt_in_reset", {61'd0, LW_GNT_O, LR_GNT_O, SY_GNT_O, MEM_EN_O}, 64'd0);
    SY_REQ_I = 0;
    step();
    RST_I = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("flush_c%0d", c), {SY_RDATA_O, 30'd0, SY_RVALID_O, LR_RVALID_O}, 64'd0);
      @(posedge CLK_I); #1;
    end
    check("flush_stall", {16'd0, STALL_CNT_O}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
